// File: rtl/ram_sp_master_if.sv
// ---------------------------------------------------------------------------
// ram_sp_master_if
//   Bundles the three channels around ram_sp_master:
//     request  : req_valid, req_ready, req_we, req_addr, req_wdata
//     response : rsp_valid, rsp_ready, rsp_rdata
//     RAM port : ram_we, ram_re, ram_addr, ram_wdata, ram_rdata
//   Modports:
//     master : view of ram_sp_master itself (drives req_ready, rsp_*, ram_*)
//     slave  : view of the surrounding logic (bus-side requester and RAM)
// ---------------------------------------------------------------------------
interface ram_sp_master_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    input  ram_rdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output ram_we, ram_re, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    output ram_rdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  ram_we, ram_re, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_sp_master.sv
// ---------------------------------------------------------------------------
// ram_sp_master
//   Initiator for a single-port synchronous RAM (one-cycle read latency).
//   Turns a valid/ready request stream into one RAM operation per clock and
//   returns read data, in request order, through a small response FIFO.
//
//   Ports:
//     clk    : clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : ram_sp_master_if.master (request, response and RAM channels)
//   Optional (macro RAM_SP_MASTER_STATS_EN):
//     stat_clr    : synchronous clear of both counters
//     stat_rd_cnt : saturating count of read fires
//     stat_wr_cnt : saturating count of write fires
//
//   Parameters: DATA_WIDTH, ADDR_WIDTH (must match the RAM), RSP_DEPTH
//   (power of 2, >= 2; >= 3 for one read per cycle).
// ---------------------------------------------------------------------------
module ram_sp_master #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_sp_master_if.master     bus
`ifdef RAM_SP_MASTER_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         stat_rd_cnt,
  output logic [15:0]         stat_wr_cnt
`endif
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] r_fifoMem [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rdPend;

  logic                  w_reqReady;
  logic                  w_fire;
  logic                  w_rdFire;
  logic                  w_wrFire;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W:0]        w_credits;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Credits in use are buffered responses plus the read still in the RAM.
  // Requests (writes included) are only accepted while a credit is free, so
  // every read that fires is guaranteed a FIFO slot when its data returns.
  always_comb begin
    w_credits  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rdPend};
    w_reqReady = rst_n && (w_credits < CREDIT_MAX);
    w_fire     = bus.req_valid && w_reqReady;
    w_rdFire   = w_fire && !bus.req_we;
    w_wrFire   = w_fire && bus.req_we;
    w_push     = r_rdPend;
    w_pop      = bus.rsp_valid && bus.rsp_ready;
    w_addr     = bus.req_addr;
  end

  // The RAM port is a straight combinational pass of the request channel;
  // the enables are qualified by the fire so an idle RAM sees we = re = 0.
  assign bus.req_ready = w_reqReady;
  assign bus.ram_we    = w_wrFire;
  assign bus.ram_re    = w_rdFire;
  assign bus.ram_addr  = w_addr;
  assign bus.ram_wdata = bus.req_wdata;

  // Head of the FIFO is presented directly; entries are reset so that
  // rsp_rdata reads 0 out of reset.
  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_rdata = r_fifoMem[r_rdPtr];

  // Response FIFO plus the one-deep read-in-flight flag. rd_pend follows
  // the read fire of the previous cycle: its data is on ram_rdata now and is
  // pushed this edge, while a new read fire re-arms the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifoMem[i] <= '0;
      end
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_rdPend <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifoMem[r_wrPtr] <= bus.ram_rdata;
        r_wrPtr            <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_rdPend <= w_rdFire;
    end
  end

  // Credit accounting makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(w_push && (r_count == CNT_FULL)));

`ifdef RAM_SP_MASTER_STATS_EN
  logic [15:0] r_statRdCnt;
  logic [15:0] r_statWrCnt;

  // Fire counters saturate at all-ones; a clear wins over an increment
  // landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statRdCnt <= '0;
      r_statWrCnt <= '0;
    end else if (stat_clr) begin
      r_statRdCnt <= '0;
      r_statWrCnt <= '0;
    end else begin
      if (w_rdFire && (r_statRdCnt != 16'hFFFF)) begin
        r_statRdCnt <= r_statRdCnt + 16'd1;
      end
      if (w_wrFire && (r_statWrCnt != 16'hFFFF)) begin
        r_statWrCnt <= r_statWrCnt + 16'd1;
      end
    end
  end

  assign stat_rd_cnt = r_statRdCnt;
  assign stat_wr_cnt = r_statWrCnt;
`endif

endmodule

// File: tb/tb_ram_sp_master.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_master
//   Directed bench for ram_sp_master with a behavioural single-port RAM
//   (one-cycle read latency, rdata held while re is low). Inputs change 1 time
//   unit after the rising edge; outputs are sampled 1-2 units after it.
// ---------------------------------------------------------------------------
module tb_ram_sp_master;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [3:0] ramMem [16];

`ifdef RAM_SP_MASTER_STATS_EN
  logic        statClr;
  logic [15:0] statRdCnt;
  logic [15:0] statWrCnt;
`endif

  ram_sp_master_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) bus ();

  ram_sp_master #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef RAM_SP_MASTER_STATS_EN
    ,
    .stat_clr   (statClr),
    .stat_rd_cnt(statRdCnt),
    .stat_wr_cnt(statWrCnt)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on we, registered read on re.
  always @(posedge clk) begin
    if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ramMem[bus.ram_addr];
  end

  // Drive one request-channel beat.
  task automatic applyStimulus(input logic v, input logic we,
                               input logic [3:0] addr, input logic [3:0] data);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
  endtask

  // Reset values, with a read request presented to show it is not accepted.
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd0);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    vectors++;
    if (bus.rsp_rdata !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata);
    end
    vectors++;
    if (bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    vectors++;
    if (bus.ram_re !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ram_re: got %b want 0", bus.ram_re);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release_req_ready: got %b want 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Write addr 3 = A, read it back the next cycle.
  task automatic test_write_then_read();
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd3, 4'hA);
    #1;
    vectors++;
    if ({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b0, 4'd3, 4'hA}) begin
      miscompares++;
      $display("[TB] FAIL wr_ram_port: got we=%b re=%b a=%h d=%h want we=1 re=0 a=3 d=a",
               bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd0);
    #1;
    vectors++;
    if ({bus.ram_we, bus.ram_re} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rd_ram_port: got we=%b re=%b want we=0 re=1", bus.ram_we, bus.ram_re);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    vectors++;
    if ({bus.ram_we, bus.ram_re, bus.rsp_valid} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL wtr_latency1: got we=%b re=%b rsp_valid=%b want 0 0 0",
               bus.ram_we, bus.ram_re, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 4'hA}) begin
      miscompares++;
      $display("[TB] FAIL wtr_response: got valid=%b data=%h want valid=1 data=a",
               bus.rsp_valid, bus.rsp_rdata);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wtr_drained: got rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  // 16 back-to-back reads of mem[i] = i with the response side always ready.
  task automatic test_streaming();
    logic readyDropped;
    for (int i = 0; i < 16; i++) ramMem[i] = 4'(i);
    readyDropped  = 1'b0;
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
    #1;
    if (bus.req_ready !== 1'b1) readyDropped = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k < 16) applyStimulus(1'b1, 1'b0, 4'(k), 4'd0);
      else        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      #1;
      if (k < 16 && bus.req_ready !== 1'b1) readyDropped = 1'b1;
      vectors++;
      if (k >= 2 && k <= 17) begin
        if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 4'(k - 2)}) begin
          miscompares++;
          $display("[TB] FAIL stream_rsp[%0d]: got valid=%b data=%h want valid=1 data=%h",
                   k, bus.rsp_valid, bus.rsp_rdata, 4'(k - 2));
        end
      end else begin
        if (bus.rsp_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stream_idle[%0d]: got valid=%b want 0", k, bus.rsp_valid);
        end
      end
    end
    vectors++;
    if (readyDropped !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_req_ready: got dropped=%b want 0", readyDropped);
    end
  endtask

  // Reads with the response side stalled: four credits, then drain.
  task automatic test_backpressure();
    int accepted;
    accepted      = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 4'(4 + accepted), 4'd0);
      #1;
      if (bus.req_ready === 1'b1) accepted++;
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    vectors++;
    if (accepted !== 4) begin
      miscompares++;
      $display("[TB] FAIL bp_accepted: got %0d want 4", accepted);
    end
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== {1'b0, 1'b1, 4'h4}) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got ready=%b valid=%b data=%h want ready=0 valid=1 data=4",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 1'b1, 4'h5}) begin
      miscompares++;
      $display("[TB] FAIL bp_first_pop: got ready=%b valid=%b data=%h want ready=1 valid=1 data=5",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
    end
    for (int d = 6; d <= 7; d++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 4'(d)}) begin
        miscompares++;
        $display("[TB] FAIL bp_drain[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 d, bus.rsp_valid, bus.rsp_rdata, 4'(d));
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_empty: got valid=%b want 0", bus.rsp_valid);
    end
  endtask

  // A buffered response is discarded by an asynchronous reset.
  task automatic test_reset_midflight();
    int spurious;
    spurious      = 0;
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 4'h2}) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre: got valid=%b data=%h want valid=1 data=2",
               bus.rsp_valid, bus.rsp_rdata);
    end
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd0);
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.ram_re} !== {1'b0, 4'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_active: got valid=%b data=%h ready=%b re=%b want 0 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.ram_re);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("[TB] FAIL midrst_spurious: got %0d responses want 0", spurious);
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_ready: got %b want 1", bus.req_ready);
    end
  endtask

  // W(5,7) R(5) W(5,2) R(5) back-to-back.
  task automatic test_back_to_back();
    logic       opWe   [4];
    logic [3:0] opData [4];
    logic [3:0] got    [2];
    int         nResp;
    opWe[0] = 1'b1; opData[0] = 4'h7;
    opWe[1] = 1'b0; opData[1] = 4'h0;
    opWe[2] = 1'b1; opData[2] = 4'h2;
    opWe[3] = 1'b0; opData[3] = 4'h0;
    got[0] = 4'h0;
    got[1] = 4'h0;
    nResp  = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) applyStimulus(1'b1, opWe[c], 4'd5, opData[c]);
      else       applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      #1;
      if (bus.rsp_valid === 1'b1) begin
        if (nResp < 2) got[nResp] = bus.rsp_rdata;
        nResp++;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (nResp !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d want 2", nResp);
    end
    vectors++;
    if (got[0] !== 4'h7) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h want 7", got[0]);
    end
    vectors++;
    if (got[1] !== 4'h2) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h want 2", got[1]);
    end
  endtask

`ifdef RAM_SP_MASTER_STATS_EN
  // Fire counters: clear, count, clear precedence, saturation.
  task automatic test_stats();
    logic       opWe [5];
    bus.rsp_ready = 1'b1;
    statClr = 1'b1;
    @(posedge clk);
    #1;
    statClr = 1'b0;
    vectors++;
    if ({statRdCnt, statWrCnt} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL stats_clr: got rd=%h wr=%h want 0 0", statRdCnt, statWrCnt);
    end
    opWe[0] = 1'b1; opWe[1] = 1'b1; opWe[2] = 1'b1; opWe[3] = 1'b0; opWe[4] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, opWe[c], 4'(c), 4'(c));
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({statRdCnt, statWrCnt} !== {16'd2, 16'd3}) begin
      miscompares++;
      $display("[TB] FAIL stats_count: got rd=%0d wr=%0d want rd=2 wr=3", statRdCnt, statWrCnt);
    end
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd0);
    statClr = 1'b1;
    @(posedge clk);
    #1;
    statClr = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    vectors++;
    if ({statRdCnt, statWrCnt} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL stats_clr_prec: got rd=%h wr=%h want 0 0", statRdCnt, statWrCnt);
    end
    repeat (3) @(posedge clk);
    #1;
    force dut.r_statRdCnt = 16'hFFFF;
    #1;
    release dut.r_statRdCnt;
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    vectors++;
    if (statRdCnt !== 16'hFFFF) begin
      miscompares++;
      $display("[TB] FAIL stats_saturate: got rd=%h want ffff", statRdCnt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  // Test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.ram_rdata = 4'h0;
    for (int i = 0; i < 16; i++) ramMem[i] = 4'h0;
`ifdef RAM_SP_MASTER_STATS_EN
    statClr = 1'b0;
`endif
    $display("[TB] ram_sp_master directed test start");
    test_reset();
    test_write_then_read();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
`ifdef RAM_SP_MASTER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
